figaro_read_sched: RTL and testbench

FIGARO_READ_SCHED -- requirements
Module: figaro_read_sched

---
 rtl/figaro_read_sched.sv | 152 +++++++++++++++
 tb/tb_figaro_read_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/figaro_read_sched.sv
// Read scheduler for a FiGaRO/SHA entropy generator: resets the generator, waits for a
// digest, then streams WORDS 32-bit words out over a valid/ready port, one word per FETCH/HOLD pair.
module figaro_read_sched #(
  parameter int unsigned WORDS      = 16,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        busy,
  output logic        trng_reset,
  output logic        trng_enable,
  input  logic        trng_ready,
  output logic [9:0]  trng_addr,
  input  logic [31:0] trng_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        err
);

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RST        = 3'd1,
    S_WAIT_READY = 3'd2,
    S_FETCH      = 3'd3,
    S_HOLD       = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                trng_reset_q, trng_reset_d;
  logic                trng_enable_q, trng_enable_d;
  logic                err_q, err_d;

  // Next-state logic; every output flop is derived from the next state so it lines up with it.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_RST;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_READY: begin
        // A digest arriving on the timeout cycle wins over the error.
        if (trng_ready) begin
          state_d = S_FETCH;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        out_data_d = trng_data;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d        = (state_d != S_IDLE);
    trng_reset_d  = (state_d == S_RST);
    trng_enable_d = (state_d == S_WAIT_READY) || (state_d == S_FETCH) || (state_d == S_HOLD);
    out_valid_d   = (state_d == S_HOLD);
    out_last_d    = (state_d == S_HOLD) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      trng_reset_q  <= 1'b0;
      trng_enable_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      trng_reset_q  <= trng_reset_d;
      trng_enable_q <= trng_enable_d;
      err_q         <= err_d;
    end
  end

  assign busy        = busy_q;
  assign trng_reset  = trng_reset_q;
  assign trng_enable = trng_enable_q;
  assign trng_addr   = idx_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign err         = err_q;

endmodule

// File: tb/tb_figaro_read_sched.sv
// Scoreboard bench for figaro_read_sched: a generator model supplies data by address,
// expected words are queued per block and a negedge monitor compares presented words.
module tb_figaro_read_sched;

  localparam int unsigned WORDS      = 16;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned TIMEOUT    = 8;
  localparam int          MAX_CYC    = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        busy;
  logic        trng_reset;
  logic        trng_enable;
  logic        trng_ready;
  logic [9:0]  trng_addr;
  logic [31:0] trng_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        err;
  logic [31:0] seed;

  typedef struct {
    logic [31:0] data;
    logic [9:0]  addr;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  figaro_read_sched #(
    .WORDS(WORDS),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .busy(busy),
    .trng_reset(trng_reset),
    .trng_enable(trng_enable),
    .trng_ready(trng_ready),
    .trng_addr(trng_addr),
    .trng_data(trng_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .err(err)
  );

  // Generator digest model: word content is a function of block seed and address.
  function automatic logic [31:0] gen_word(input logic [31:0] s, input logic [9:0] a);
    return s ^ ({22'd0, a} * 32'h9E37_79B9) ^ {a, 22'h2a5a5};
  endfunction

  assign trng_data = gen_word(seed, trng_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented word must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word at %0t", out_data, $time);
      end else begin
        check("word_data", out_data, sb_q[0].data);
        check("word_addr", 32'(trng_addr), 32'(sb_q[0].addr));
        check("word_last", 32'(out_last), 32'(sb_q[0].last));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  // One req-initiated block. w = WAIT_READY cycles before the digest (w > TIMEOUT: never).
  task automatic run_block(input int w, input int bp_word, input int bp_len,
                           input bit rnd_bp, input bit noisy, input int abort_word);
    int c, hs, bp_left, first_valid, rst_hi, err_hi, end_c;
    bit done, to, aborted, req_pulsed, prev_hold;
    to = (w > int'(TIMEOUT));
    hs = 0; bp_left = bp_len; first_valid = -1; rst_hi = 0; err_hi = 0; end_c = 0;
    done = 0; aborted = 0; req_pulsed = 0; prev_hold = 0;
    @(posedge clk); #1;
    seed = $urandom; req = 1'b1; trng_ready = 1'b0; out_ready = 1'b1;
    if (!to)
      for (int i = 0; i < int'(WORDS); i++)
        sb_q.push_back('{gen_word(seed, 10'(i)), 10'(i), (i == int'(WORDS) - 1)});
    for (c = 0; c < MAX_CYC; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        req = 1'b0;
        trng_ready = (c >= int'(RST_CYCLES) + w) ? 1'b1 : 1'b0;
        if (noisy && first_valid >= 0) begin
          trng_ready = 1'($urandom_range(0, 1));
          if (prev_hold && !req_pulsed) begin
            req = 1'b1;
            req_pulsed = 1'b1;
          end
        end
        out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hs == bp_word && bp_left > 0) out_ready = 1'b0;
      end
      @(negedge clk);
      if (trng_reset) rst_hi++;
      if (err) err_hi++;
      if (c == 0) check("idle_busy_at_req", 32'(busy), 32'd0);
      if (c >= 1 && c <= int'(RST_CYCLES)) begin
        check("rst_trng_reset", 32'(trng_reset), 32'd1);
        check("rst_trng_enable", 32'(trng_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
      end
      if (c > int'(RST_CYCLES) && !done) begin
        if (to && c == int'(RST_CYCLES + TIMEOUT) + 1) begin
          check("timeout_err", 32'(err), 32'd1);
          check("timeout_busy", 32'(busy), 32'd0);
          check("timeout_enable", 32'(trng_enable), 32'd0);
          done = 1'b1;
          end_c = c;
        end else begin
          check("run_enable", 32'(trng_enable), 32'd1);
          check("run_trng_reset", 32'(trng_reset), 32'd0);
          check("run_busy", 32'(busy), 32'd1);
        end
      end
      if (out_valid && first_valid < 0) begin
        first_valid = c;
        check("first_valid_latency", 32'(c), 32'(int'(RST_CYCLES) + w + 2));
      end
      if (abort_word >= 0 && out_valid && hs == abort_word) begin
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_trng_reset", 32'(trng_reset), 32'd0);
        check("abort_enable", 32'(trng_enable), 32'd0);
        check("abort_addr", 32'(trng_addr), 32'd0);
        check("abort_data", out_data, 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (bp_left > 0 && out_valid && !out_ready && hs == bp_word) bp_left--;
      prev_hold = out_valid && !out_ready;
      if (out_valid && out_ready && !done) begin
        hs++;
        if (hs == int'(WORDS)) begin
          done = 1'b1;
          end_c = c;
        end
      end
      if (done && c > end_c) begin
        check("end_busy", 32'(busy), 32'd0);
        check("end_enable", 32'(trng_enable), 32'd0);
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_addr", 32'(trng_addr), 32'd0);
        check("end_err", 32'(err), 32'd0);
        if (c == end_c + 2) break;
      end
    end
    if (c >= MAX_CYC) begin
      checks++;
      errors++;
      $display("FAIL block_bound: got no completion expected completion within %0d cycles", MAX_CYC);
    end
    check("trng_reset_cycles", 32'(rst_hi), 32'(RST_CYCLES));
    if (!aborted) begin
      check("err_cycles", 32'(err_hi), to ? 32'd1 : 32'd0);
      check("words_done", 32'(hs), to ? 32'd0 : 32'(WORDS));
      check("queue_empty", 32'(sb_q.size()), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; trng_ready = 1'b0; out_ready = 1'b0; seed = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trng_reset", 32'(trng_reset), 32'd0);
    check("rst_trng_enable", 32'(trng_enable), 32'd0);
    check("rst_addr", 32'(trng_addr), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    run_block(5, -1, 0, 1'b0, 1'b0, -1);       // nominal
    run_block(5, 3, 7, 1'b0, 1'b0, -1);        // backpressure on word 3
    run_block(1000, -1, 0, 1'b0, 1'b0, -1);    // timeout
    run_block(int'(TIMEOUT), -1, 0, 1'b0, 1'b0, -1); // digest on last WAIT cycle
    run_block(4, -1, 0, 1'b0, 1'b0, 6);        // async reset mid-HOLD at word 6
    run_block(5, -1, 0, 1'b0, 1'b0, -1);       // restart from address 0
    run_block(3, 3, 4, 1'b0, 1'b1, -1);        // req during HOLD, ready noise
    for (int k = 0; k < 6; k++)
      run_block(int'($urandom_range(1, TIMEOUT)), int'($urandom_range(0, WORDS - 1)),
                int'($urandom_range(0, 5)), 1'b1, 1'($urandom_range(0, 1)), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
